// File: rtl/mole_pkg.sv
// mole_pkg: shared state type and constants for the mole game controller.
// Holds the round FSM state enum, the hidden-mole encoding and the LFSR tap mask.
package mole_pkg;
    typedef enum logic [1:0] {IDLE, PLAYING, PAUSED, OVER} game_state_t;
    localparam logic [1:0] MOLE_HIDDEN = 2'b00;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/mole_scheduler_if.sv
// mole_scheduler_if: button/mole-array bus of the game controller.
// master: drives start_btn, pause_btn, mole_states; observes the controller outputs.
// slave:  the controller; drives start_moles, pause, clear_moles, time_left, playing, game_over.
interface mole_scheduler_if;
    logic        start_btn;
    logic        pause_btn;
    logic [31:0] mole_states;
    logic [15:0] start_moles;
    logic        pause;
    logic        clear_moles;
    logic [6:0]  time_left;
    logic        playing;
    logic        game_over;
    modport master (
        output start_btn, pause_btn, mole_states,
        input  start_moles, pause, clear_moles, time_left, playing, game_over
    );
    modport slave (
        input  start_btn, pause_btn, mole_states,
        output start_moles, pause, clear_moles, time_left, playing, game_over
    );
endinterface

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR with a configurable non-zero seed.
// Ports: clk, rst_n (async active-low, loads SEED), state (current LFSR value).
module lfsr16
    import mole_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SEED;
        else state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: round FSM, seconds countdown and pseudo-random spawn scheduler for sixteen moles.
// Optional feature: define MOLE_SPEEDUP_EN to halve the spawn period once less than half the round remains.
// Ports: animation_clk (sole clock), rst_n (async active-low), bus (mole_scheduler_if.slave):
//   in  start_btn, pause_btn, mole_states[31:0]
//   out start_moles[15:0], pause, clear_moles, time_left[6:0], playing, game_over
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int          TICKS_PER_SEC = 16,
    parameter int          GAME_SECONDS  = 60,
    parameter int          SPAWN_TICKS   = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input logic             animation_clk,
    input logic             rst_n,
    mole_scheduler_if.slave bus
);
    localparam int TW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
    localparam int SW = $clog2(SPAWN_TICKS);
    localparam logic [TW-1:0] TICK_RELOAD = TW'(TICKS_PER_SEC - 1);
    localparam logic [SW-1:0] SPAWN_FULL  = SW'(SPAWN_TICKS - 1);
    localparam logic [6:0]    GAME_TIME   = 7'(GAME_SECONDS);

    game_state_t   state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [SW-1:0] spawn_q, spawn_d, spawn_reload;
    logic [6:0]    time_q, time_d;
    logic [15:0]   start_q, start_d, hidden, pick, lfsr;
    logic          clear_q, clear_d, found, unused_lfsr;
    logic [3:0]    idx;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (animation_clk),
        .rst_n (rst_n),
        .state (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:4];

    for (genvar i = 0; i < 16; i++) begin : g_hidden
        assign hidden[i] = bus.mole_states[2*i +: 2] == MOLE_HIDDEN;
    end

`ifdef MOLE_SPEEDUP_EN
    localparam logic [6:0]    HALF_TIME  = 7'(GAME_SECONDS / 2);
    localparam logic [SW-1:0] SPAWN_FAST = SW'(SPAWN_TICKS / 2 - 1);
    assign spawn_reload = (time_q < HALF_TIME) ? SPAWN_FAST : SPAWN_FULL;
`else
    assign spawn_reload = SPAWN_FULL;
`endif

    // Scan from the LFSR candidate upward with 4-bit wrap; first hidden mole wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < 16; k++) begin
            idx = lfsr[3:0] + 4'(k);
            if (!found && hidden[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    // A pause_btn cycle in PLAYING already freezes the counters, so the
    // values seen on resume are exactly those held when the button hit.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        spawn_d = spawn_q;
        time_d  = time_q;
        start_d = '0;
        clear_d = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (bus.start_btn) begin
                    state_d = PLAYING;
                    clear_d = 1'b1;
                    time_d  = GAME_TIME;
                    tick_d  = TICK_RELOAD;
                    spawn_d = SPAWN_FULL;
                end
            end
            PAUSED: state_d = bus.pause_btn ? PLAYING : PAUSED;
            PLAYING: begin
                if (bus.pause_btn) begin
                    state_d = PAUSED;
                end else begin
                    tick_d  = (tick_q == '0) ? TICK_RELOAD : tick_q - TW'(1);
                    time_d  = (tick_q == '0) ? time_q - 7'd1 : time_q;
                    spawn_d = (spawn_q == '0) ? spawn_reload : spawn_q - SW'(1);
                    if (tick_q == '0 && time_q == 7'd1) state_d = OVER;
                    else if (spawn_q == '0) start_d = pick;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge animation_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            spawn_q <= '0;
            time_q  <= '0;
            start_q <= '0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            spawn_q <= spawn_d;
            time_q  <= time_d;
            start_q <= start_d;
            clear_q <= clear_d;
        end
    end

    assign bus.start_moles = start_q;
    assign bus.clear_moles = clear_q;
    assign bus.time_left   = time_q;
    assign bus.playing     = state_q == PLAYING;
    assign bus.pause       = state_q != PLAYING;
    assign bus.game_over   = state_q == OVER;
endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Game controller that sequences the sixteen-mole array. It owns the round FSM (idle, playing, paused, over), a seconds countdown, and a pseudo-random spawn scheduler that issues one-cycle `start_moles` pulses only to moles currently hidden. It drives the array's `pause` and a score/mole clear pulse, and sits between the debounced button front-end and `sixteen_moles`.

## Interface
- `TICKS_PER_SEC`, default 16: `animation_clk` cycles per game second.
- `GAME_SECONDS`, default 60: round length in seconds; must be in 1..127.
- `SPAWN_TICKS`, default 8: cycles between spawn attempts; must be ≥2.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- `animation_clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_btn` in 1: debounced single-cycle start pulse.
- `pause_btn` in 1: debounced single-cycle pause-toggle pulse.
- `mole_states` in 32: 2 bits per mole, mole i at [2i+1:2i]; `2'b00` means hidden/idle.
- `start_moles` out 16: one-hot, one-cycle spawn pulse.
- `pause` out 1: freeze to the mole array.
- `clear_moles` out 1: one-cycle pulse to reset moles and score.
- `time_left` out 7: remaining seconds.
- `playing` out 1: high in PLAYING.
- `game_over` out 1: high in OVER.

## Operation
- FSM states: IDLE, PLAYING, PAUSED, OVER. Reset enters IDLE.
- IDLE/OVER + `start_btn` → PLAYING:
  - `clear_moles` pulses for 1 cycle.
  - `time_left` ← GAME_SECONDS.
  - Tick counter ← TICKS_PER_SEC-1.
  - Spawn counter ← SPAWN_TICKS-1.
- PLAYING + `pause_btn` → PAUSED; PAUSED + `pause_btn` → PLAYING. All counters hold while PAUSED.
- `start_btn` is ignored in PLAYING and PAUSED. `pause_btn` is ignored in IDLE and OVER. When both arrive in the same cycle, only the one legal in the current state acts.
- Timer, in PLAYING only:
  - The tick counter counts down each cycle.
  - When it is 0 it reloads and `time_left` decrements.
  - When `time_left` goes 1→0 the FSM enters OVER in that same cycle.
  - No spawn is issued on that cycle.
- Spawn, in PLAYING only:
  - When the spawn counter is 0: candidate = `lfsr[3:0]`.
  - If candidate is hidden, pulse it. Otherwise scan candidate+1, +2, … modulo 16 and pulse the first hidden mole.
  - If all 16 moles are non-hidden, no pulse is issued.
  - The spawn counter reloads in every case.
- LFSR: 16-bit Galois, taps mask 16'hB400. It advances every cycle in every state, so user start timing seeds the sequence.
- Outputs:
  - `pause` = 1 in IDLE, PAUSED and OVER; 0 in PLAYING.
  - `start_moles` is always zero outside PLAYING.
- Reset mid-round: everything returns to reset values immediately. No `clear_moles` pulse is issued.

## Timing
- Reset values:
  - FSM IDLE; `start_moles` 0; `clear_moles` 0; `pause` 1.
  - `time_left` 0; `playing` 0; `game_over` 0; LFSR = LFSR_SEED.
- All outputs are registered. `start_moles` asserts one cycle after the spawn counter reaches 0, using `mole_states` sampled on that cycle.
- `clear_moles`, `playing` and the `pause` deassertion all rise in the cycle after `start_btn`.
- First spawn pulse appears SPAWN_TICKS+1 cycles after `start_btn`.
- First `time_left` decrement happens TICKS_PER_SEC cycles after entering PLAYING.
- `game_over` asserts one cycle after the final decrement.

## Configuration
- `MOLE_SPEEDUP_EN` defined: once `time_left` < GAME_SECONDS/2 (integer division), the spawn reload value is SPAWN_TICKS/2−1, so the spawn period halves.
- Not defined: the spawn reload is always SPAWN_TICKS−1.

## Structure
- Shared package `mole_pkg` holds:
  - `game_state_t` enum (IDLE, PLAYING, PAUSED, OVER).
  - `MOLE_HIDDEN` = 2'b00.
  - `LFSR_TAPS` = 16'hB400.
- One sub-module, `lfsr16`: seed parameter, free-running, exposes the 16-bit state.
- The rotate-and-find-first-hidden selector and the FSM/counters stay in `mole_scheduler`.

## Test plan
- Reset held low, then released → `pause`=1, `time_left`=0, `start_moles`=0, `playing`=0.
- `start_btn` pulse, all moles hidden, TICKS_PER_SEC=4, SPAWN_TICKS=3, GAME_SECONDS=2:
  - `clear_moles` pulses once.
  - One-hot `start_moles` pulses every 3 cycles.
  - `time_left` reads 2→1→0 at 4-cycle steps.
  - `game_over`=1 after 8 cycles; no pulses afterwards.
- Spawn with candidate=15 and moles 15, 0 and 1 non-hidden → `start_moles` = 16'h0004. With all moles non-hidden → no pulse, and the next attempt comes 3 cycles later.
- `pause_btn` mid-round → `pause`=1 and `time_left` frozen for 20 cycles. Second `pause_btn` → counting resumes from the exact held counter values.
- `start_btn` and `pause_btn` asserted together in IDLE → PLAYING entered, no pause. Same pair in PLAYING → PAUSED, no clear.
- With `MOLE_SPEEDUP_EN`, SPAWN_TICKS=8, GAME_SECONDS=4 → spawn period is 8 cycles until `time_left`=1, then 4 cycles. Assert `rst_n` low mid-round → immediate IDLE with reset values.
